renkon_layer_sched: RTL and testbench
=====================================

RENKON_LAYER_SCHED -- requirements
Module: renkon_layer_sched

Interface
REQ-001 Parameter: LWIDTH, 10, width of every network-size field driven to the renkon core.
REQ-002 Parameter: IMGSIZE, 12, image-memory address width.
REQ-003 Parameter: RENKON_NETSIZE, 11, network-memory address width.
REQ-004 Parameter: MAXLAYER, 8, descriptor-table depth; a power of two.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 xrst  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle pulse that launches a sequence.
REQ-008 num_layers  in  $clog2(MAXLAYER)+1  number of layers to run; sampled on the accepted start.
REQ-009 img_base_a / img_base_b  in  IMGSIZE each  ping-pong image buffer bases; sampled on the accepted start.
REQ-010 cfg_we  in  1  descriptor write strobe.
REQ-011 cfg_layer  in  $clog2(MAXLAYER)  descriptor index.
REQ-012 cfg_field  in  3  field select: 0 total_out, 1 total_in, 2 img_size, 3 conv_size, 4 conv_pad, 5 pool_size, 6 net_offset; 7 is reserved.
REQ-013 cfg_wdata  in  16  field value; LSB-truncated to the field width.
REQ-014 ack  in  1  layer-complete pulse from the renkon core.
REQ-015 req  out  1  layer-start pulse to the renkon core.
REQ-016 total_out, total_in, img_size, conv_size, conv_pad, pool_size  out  LWIDTH each  current layer parameters.
REQ-017 net_offset  out  RENKON_NETSIZE  current layer network base.
REQ-018 in_offset / out_offset  out  IMGSIZE each  current layer image source and destination bases.
REQ-019 busy  out  1  high from an accepted start until done.
REQ-020 done  out  1  one-cycle pulse at sequence end.
REQ-021 layer_idx  out  $clog2(MAXLAYER)  index of the current layer.

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD, REQ, WAIT and NEXT.
REQ-023 IDLE: start -> LOAD with busy=1 and layer_idx=0, except when num_layers==0, which gives done=1 on the next cycle and stays IDLE with no req.
REQ-024 num_layers greater than MAXLAYER SHALL saturate to MAXLAYER.
REQ-025 LOAD (1 cycle): register descriptor[layer_idx] onto the parameter outputs, then -> REQ.
REQ-026 In LOAD, in_offset/out_offset SHALL be A/B for even layer_idx and B/A for odd layer_idx.
REQ-027 REQ (1 cycle): req=1, then -> WAIT.
REQ-028 Parameter outputs SHALL stay stable from LOAD until the ack of that layer.
REQ-029 WAIT: on ack -> NEXT; there is no timeout.
REQ-030 NEXT: if layer_idx==count-1 -> IDLE with done=1 and busy=0 in that same cycle; otherwise layer_idx+1 -> LOAD.
REQ-031 Latency: req SHALL assert 2 cycles after start; the next req SHALL assert 3 cycles after each intermediate ack; done SHALL follow the last ack by 1 cycle.
REQ-032 ack outside WAIT, and ack coincident with req, SHALL be ignored.
REQ-033 start while busy SHALL be ignored.
REQ-034 cfg_we while busy SHALL be ignored (the table is frozen during a run); cfg_we in IDLE SHALL write in 1 cycle.
REQ-035 cfg_we coincident with an accepted start SHALL write first, so the new value is visible to layer 0.
REQ-036 cfg_field==7 SHALL be a no-op.
REQ-037 done and busy SHALL never be high in the same cycle.

Reset
REQ-038 On xrst low, asynchronously: state=IDLE, req=0, busy=0, done=0, layer_idx=0, all parameter and offset outputs=0, all descriptor fields=0, sampled count and bases=0.
REQ-039 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL accept a new start.

Verification
REQ-040 Program 3 layers; start with num_layers=3, A=0x000, B=0x800 -> 3 req pulses; offsets (0,800),(800,0),(0,800); one done after the 3rd ack; busy low the same cycle.
REQ-041 start with num_layers=0 -> done 1 cycle later; req never high; busy never high.
REQ-042 start and cfg_we while in WAIT; spurious ack in IDLE -> no effect, table unchanged, no req.
REQ-043 Write conv_size=0xFFFF -> output reads 0x3FF (LWIDTH=10); cfg_field=7 leaves the table unchanged.
REQ-044 Assert xrst during layer 1 WAIT -> all outputs 0 immediately, no done; a new start runs from layer 0.
REQ-045 num_layers=15 with MAXLAYER=8 -> exactly 8 req pulses, then done.

Source files
------------

// File: rtl/renkon_layer_sched_if.sv
// Host/core-facing bundle of the renkon layer scheduler: launch controls,
// descriptor writes, the req/ack handshake and the per-layer parameters.
interface renkon_layer_sched_if #(
    parameter int LWIDTH         = 10,
    parameter int IMGSIZE        = 12,
    parameter int RENKON_NETSIZE = 11,
    parameter int MAXLAYER       = 8
);
    localparam int LIW = $clog2(MAXLAYER);
    localparam int CW  = LIW + 1;

    logic                      start;
    logic [CW-1:0]             num_layers;
    logic [IMGSIZE-1:0]        img_base_a;
    logic [IMGSIZE-1:0]        img_base_b;
    logic                      cfg_we;
    logic [LIW-1:0]            cfg_layer;
    logic [2:0]                cfg_field;
    logic [15:0]               cfg_wdata;
    logic                      ack;
    logic                      req;
    logic [LWIDTH-1:0]         total_out;
    logic [LWIDTH-1:0]         total_in;
    logic [LWIDTH-1:0]         img_size;
    logic [LWIDTH-1:0]         conv_size;
    logic [LWIDTH-1:0]         conv_pad;
    logic [LWIDTH-1:0]         pool_size;
    logic [RENKON_NETSIZE-1:0] net_offset;
    logic [IMGSIZE-1:0]        in_offset;
    logic [IMGSIZE-1:0]        out_offset;
    logic                      busy;
    logic                      done;
    logic [LIW-1:0]            layer_idx;

    modport master (
        output start, num_layers, img_base_a, img_base_b,
               cfg_we, cfg_layer, cfg_field, cfg_wdata, ack,
        input  req, total_out, total_in, img_size, conv_size, conv_pad,
               pool_size, net_offset, in_offset, out_offset, busy, done, layer_idx
    );

    modport slave (
        input  start, num_layers, img_base_a, img_base_b,
               cfg_we, cfg_layer, cfg_field, cfg_wdata, ack,
        output req, total_out, total_in, img_size, conv_size, conv_pad,
               pool_size, net_offset, in_offset, out_offset, busy, done, layer_idx
    );
endinterface

// File: rtl/renkon_layer_sched.sv
// Walks a descriptor table layer by layer, driving one req per layer to the
// renkon core and ping-ponging the image buffers between layers.
//
// state  | meaning
// IDLE   | waiting for start; descriptor table writable
// LOAD   | latch descriptor[layer_idx] and buffer offsets onto the outputs
// REQ    | one-cycle req pulse to the core
// WAIT   | waiting for the core's ack
// NEXT   | advance to the next layer or finish
module renkon_layer_sched #(
    parameter int LWIDTH         = 10,
    parameter int IMGSIZE        = 12,
    parameter int RENKON_NETSIZE = 11,
    parameter int MAXLAYER       = 8
) (
    input logic                 clk,
    input logic                 xrst,
    renkon_layer_sched_if.slave bus
);
    localparam int LIW = $clog2(MAXLAYER);
    localparam int CW  = LIW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_NEXT} state_t;

    state_t                    state_q, state_d;
    logic [LIW-1:0]            layer_idx_q, layer_idx_d;
    logic [CW-1:0]             count_q, count_d;
    logic [IMGSIZE-1:0]        base_a_q, base_a_d, base_b_q, base_b_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic [LWIDTH-1:0]         tout_q, tout_d, tin_q, tin_d, isz_q, isz_d;
    logic [LWIDTH-1:0]         csz_q, csz_d, cpad_q, cpad_d, psz_q, psz_d;
    logic [RENKON_NETSIZE-1:0] noff_q, noff_d;
    logic [IMGSIZE-1:0]        ioff_q, ioff_d, ooff_q, ooff_d;

    logic [LWIDTH-1:0]         tab_tout_q [MAXLAYER];
    logic [LWIDTH-1:0]         tab_tin_q  [MAXLAYER];
    logic [LWIDTH-1:0]         tab_isz_q  [MAXLAYER];
    logic [LWIDTH-1:0]         tab_csz_q  [MAXLAYER];
    logic [LWIDTH-1:0]         tab_cpad_q [MAXLAYER];
    logic [LWIDTH-1:0]         tab_psz_q  [MAXLAYER];
    logic [RENKON_NETSIZE-1:0] tab_noff_q [MAXLAYER];

    logic [CW-1:0] nsat_w;
    logic          last_w;

    assign nsat_w = (bus.num_layers > CW'(MAXLAYER)) ? CW'(MAXLAYER) : bus.num_layers;
    assign last_w = ({1'b0, layer_idx_q} == (count_q - CW'(1)));

    // Table is frozen outside IDLE; a write alongside start lands before LOAD reads it.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < MAXLAYER; i++) begin
                tab_tout_q[i] <= '0;
                tab_tin_q[i]  <= '0;
                tab_isz_q[i]  <= '0;
                tab_csz_q[i]  <= '0;
                tab_cpad_q[i] <= '0;
                tab_psz_q[i]  <= '0;
                tab_noff_q[i] <= '0;
            end
        end else if (bus.cfg_we && (state_q == S_IDLE)) begin
            case (bus.cfg_field)
                3'd0: tab_tout_q[bus.cfg_layer] <= bus.cfg_wdata[LWIDTH-1:0];
                3'd1: tab_tin_q[bus.cfg_layer]  <= bus.cfg_wdata[LWIDTH-1:0];
                3'd2: tab_isz_q[bus.cfg_layer]  <= bus.cfg_wdata[LWIDTH-1:0];
                3'd3: tab_csz_q[bus.cfg_layer]  <= bus.cfg_wdata[LWIDTH-1:0];
                3'd4: tab_cpad_q[bus.cfg_layer] <= bus.cfg_wdata[LWIDTH-1:0];
                3'd5: tab_psz_q[bus.cfg_layer]  <= bus.cfg_wdata[LWIDTH-1:0];
                3'd6: tab_noff_q[bus.cfg_layer] <= bus.cfg_wdata[RENKON_NETSIZE-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= S_IDLE;
            layer_idx_q <= '0;
            count_q     <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tout_q      <= '0;
            tin_q       <= '0;
            isz_q       <= '0;
            csz_q       <= '0;
            cpad_q      <= '0;
            psz_q       <= '0;
            noff_q      <= '0;
            ioff_q      <= '0;
            ooff_q      <= '0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            count_q     <= count_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tout_q      <= tout_d;
            tin_q       <= tin_d;
            isz_q       <= isz_d;
            csz_q       <= csz_d;
            cpad_q      <= cpad_d;
            psz_q       <= psz_d;
            noff_q      <= noff_d;
            ioff_q      <= ioff_d;
            ooff_q      <= ooff_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        count_d     = count_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tout_d      = tout_q;
        tin_d       = tin_q;
        isz_d       = isz_q;
        csz_d       = csz_q;
        cpad_d      = cpad_q;
        psz_d       = psz_q;
        noff_d      = noff_q;
        ioff_d      = ioff_q;
        ooff_d      = ooff_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (nsat_w == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_LOAD;
                        busy_d      = 1'b1;
                        layer_idx_d = '0;
                        count_d     = nsat_w;
                        base_a_d    = bus.img_base_a;
                        base_b_d    = bus.img_base_b;
                    end
                end
            end
            S_LOAD: begin
                tout_d  = tab_tout_q[layer_idx_q];
                tin_d   = tab_tin_q[layer_idx_q];
                isz_d   = tab_isz_q[layer_idx_q];
                csz_d   = tab_csz_q[layer_idx_q];
                cpad_d  = tab_cpad_q[layer_idx_q];
                psz_d   = tab_psz_q[layer_idx_q];
                noff_d  = tab_noff_q[layer_idx_q];
                ioff_d  = layer_idx_q[0] ? base_b_q : base_a_q;
                ooff_d  = layer_idx_q[0] ? base_a_q : base_b_q;
                state_d = S_REQ;
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                // Final ack drops busy and raises done together so NEXT shows done alone.
                if (bus.ack) begin
                    state_d = S_NEXT;
                    if (last_w) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (last_w) begin
                    state_d = S_IDLE;
                end else begin
                    layer_idx_d = layer_idx_q + LIW'(1);
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req        = (state_q == S_REQ);
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.layer_idx  = layer_idx_q;
    assign bus.total_out  = tout_q;
    assign bus.total_in   = tin_q;
    assign bus.img_size   = isz_q;
    assign bus.conv_size  = csz_q;
    assign bus.conv_pad   = cpad_q;
    assign bus.pool_size  = psz_q;
    assign bus.net_offset = noff_q;
    assign bus.in_offset  = ioff_q;
    assign bus.out_offset = ooff_q;
endmodule

// File: tb/tb_renkon_layer_sched.sv
// Directed bench for renkon_layer_sched: expected layer records are queued at
// start and checked against the outputs on every req pulse.
module tb_renkon_layer_sched;
    logic clk;
    logic xrst;

    renkon_layer_sched_if #(.LWIDTH(10), .IMGSIZE(12), .RENKON_NETSIZE(11), .MAXLAYER(8)) bus ();

    renkon_layer_sched #(.LWIDTH(10), .IMGSIZE(12), .RENKON_NETSIZE(11), .MAXLAYER(8)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic [9:0]  tout;
        logic [9:0]  tin;
        logic [9:0]  isz;
        logic [9:0]  csz;
        logic [9:0]  cpad;
        logic [9:0]  psz;
        logic [10:0] noff;
        logic [11:0] ioff;
        logic [11:0] ooff;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_tab [8][7];
    int          vecs = 0;
    int          errs = 0;
    int          req_cnt = 0, done_cnt = 0, busy_cnt = 0, ovl_cnt = 0;

    always @(negedge clk) begin
        if (xrst) begin
            if (bus.req)              req_cnt++;
            if (bus.done)             done_cnt++;
            if (bus.busy)             busy_cnt++;
            if (bus.busy && bus.done) ovl_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int i, input logic [11:0] a, input logic [11:0] b);
        exp_t e;
        e.idx  = 3'(i);
        e.tout = m_tab[i][0][9:0];
        e.tin  = m_tab[i][1][9:0];
        e.isz  = m_tab[i][2][9:0];
        e.csz  = m_tab[i][3][9:0];
        e.cpad = m_tab[i][4][9:0];
        e.psz  = m_tab[i][5][9:0];
        e.noff = m_tab[i][6][10:0];
        e.ioff = i[0] ? b : a;
        e.ooff = i[0] ? a : b;
        return e;
    endfunction

    function automatic exp_t obs_now();
        exp_t o;
        o.idx  = bus.layer_idx;
        o.tout = bus.total_out;
        o.tin  = bus.total_in;
        o.isz  = bus.img_size;
        o.csz  = bus.conv_size;
        o.cpad = bus.conv_pad;
        o.psz  = bus.pool_size;
        o.noff = bus.net_offset;
        o.ioff = bus.in_offset;
        o.ooff = bus.out_offset;
        return o;
    endfunction

    task automatic cfg_wr(input int layer, input int field, input logic [15:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_layer = 3'(layer);
        bus.cfg_field = 3'(field);
        bus.cfg_wdata = data;
        if (field < 7) m_tab[layer][field] = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic program_layers(input int n, input int salt);
        for (int l = 0; l < n; l++)
            for (int f = 0; f < 7; f++)
                cfg_wr(l, f, 16'((l * 7 + f * 3 + salt) * 16'h0093));
    endtask

    task automatic run_seq(input int n_req, input logic [3:0] nl, input logic [11:0] a,
                           input logic [11:0] b, input bit spur, input bit meddle);
        int   lat;
        int   r0;
        int   d0;
        exp_t e;
        for (int i = 0; i < n_req; i++) sb.push_back(mk_exp(i, a, b));
        r0 = req_cnt;
        d0 = done_cnt;
        bus.start      = 1'b1;
        bus.num_layers = nl;
        bus.img_base_a = a;
        bus.img_base_b = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        lat = 1;
        for (int i = 0; i < n_req; i++) begin
            while (!bus.req && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("req_latency_l%0d", i), 128'(lat), 128'((i == 0) ? 2 : 3));
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chk($sformatf("params_at_req_l%0d", i), obs_now(), e);
            if (spur && i == 0) bus.ack = 1'b1;
            @(negedge clk);
            bus.ack = 1'b0;
            if (meddle && i == 0) begin
                bus.start      = 1'b1;
                bus.num_layers = 4'd1;
                bus.cfg_we     = 1'b1;
                bus.cfg_layer  = 3'd1;
                bus.cfg_field  = 3'd0;
                bus.cfg_wdata  = 16'h02AA;
                @(negedge clk);
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            repeat (2) @(negedge clk);
            chk($sformatf("params_hold_l%0d", i), obs_now(), e);
            bus.ack = 1'b1;
            @(negedge clk);
            bus.ack = 1'b0;
            if (i == n_req - 1)
                chk("done_busy_after_last_ack", {bus.done, bus.busy}, 2'b10);
            lat = 1;
        end
        repeat (3) @(negedge clk);
        chk("req_pulse_count", 128'(req_cnt - r0), 128'(n_req));
        chk("done_pulse_count", 128'(done_cnt - d0), 128'(1));
    endtask

    initial begin
        int r0;
        int d0;
        int b0;
        int lat;
        for (int l = 0; l < 8; l++)
            for (int f = 0; f < 7; f++) m_tab[l][f] = '0;
        xrst           = 1'b0;
        bus.start      = 1'b0;
        bus.num_layers = '0;
        bus.img_base_a = '0;
        bus.img_base_b = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_layer  = '0;
        bus.cfg_field  = '0;
        bus.cfg_wdata  = '0;
        bus.ack        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_params", obs_now(), '0);
        chk("reset_flags", {bus.req, bus.busy, bus.done}, 3'b000);
        xrst = 1'b1;
        @(negedge clk);

        // Three-layer run with ping-pong offsets; ack during req is ignored.
        program_layers(3, 1);
        run_seq(3, 4'd3, 12'h000, 12'h800, 1'b1, 1'b0);

        // Zero-layer start: immediate done, nothing else.
        r0 = req_cnt; d0 = done_cnt; b0 = busy_cnt;
        bus.start      = 1'b1;
        bus.num_layers = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_layers_done", {bus.done, bus.busy}, 2'b10);
        repeat (4) @(negedge clk);
        chk("zero_layers_no_req", 128'(req_cnt - r0), 128'(0));
        chk("zero_layers_no_busy", 128'(busy_cnt - b0), 128'(0));
        chk("zero_layers_one_done", 128'(done_cnt - d0), 128'(1));

        // Ack while idle must not start anything.
        r0 = req_cnt;
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ack_no_req", 128'(req_cnt - r0), 128'(0));
        chk("idle_ack_not_busy", 128'(bus.busy), 128'(0));

        // start and cfg_we during WAIT are ignored.
        run_seq(2, 4'd2, 12'h010, 12'h020, 1'b0, 1'b1);

        // Truncation, reserved field, and write coincident with start.
        cfg_wr(0, 3, 16'hFFFF);
        cfg_wr(0, 7, 16'h1234);
        bus.cfg_we    = 1'b1;
        bus.cfg_layer = 3'd0;
        bus.cfg_field = 3'd0;
        bus.cfg_wdata = 16'h0155;
        m_tab[0][0]   = 16'h0155;
        run_seq(1, 4'd1, 12'h0F0, 12'h00F, 1'b0, 1'b0);
        chk("conv_size_truncated", 128'(bus.conv_size), 128'(10'h3FF));

        // Reset during layer 1 WAIT aborts with no done.
        bus.start      = 1'b1;
        bus.num_layers = 4'd3;
        bus.img_base_a = 12'h100;
        bus.img_base_b = 12'h200;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.req && lat < 20) begin @(negedge clk); lat++; end
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        lat = 0;
        while (!bus.req && lat < 20) begin @(negedge clk); lat++; end
        @(negedge clk);
        chk("abort_in_layer1", 128'(bus.layer_idx), 128'(1));
        d0 = done_cnt;
        xrst = 1'b0;
        #1;
        chk("abort_params_zero", obs_now(), '0);
        chk("abort_flags_zero", {bus.req, bus.busy, bus.done}, 3'b000);
        @(negedge clk);
        xrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
        for (int l = 0; l < 8; l++)
            for (int f = 0; f < 7; f++) m_tab[l][f] = '0;
        run_seq(1, 4'd1, 12'h0AB, 12'h0CD, 1'b0, 1'b0);

        // num_layers above MAXLAYER saturates to eight layers.
        program_layers(8, 5);
        run_seq(8, 4'd15, 12'h123, 12'h456, 1'b0, 1'b0);

        chk("busy_done_overlap", 128'(ovl_cnt), 128'(0));
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
